// File: rtl/pe_cu_pkg.sv
// Shared types and constants for the BRAM -> CU -> PE sequencer.
// Optional build macro used by the top: PE_CU_SEQ_PERF_EN.
package pe_cu_pkg;

  localparam int PKG_AW      = 3;
  localparam int PKG_DW      = 32;
  localparam int NBANK       = 8;
  localparam int RD_LAT_DEF  = 1;
  localparam int CU_LAT_DEF  = 1;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_PIPE,
    WAIT_PE,
    DONE
  } state_t;

endpackage

// File: rtl/pe_cu_wait_cnt.sv
// Loadable down-counter shared by the pipeline wait and the pe_v timeout.
// 'last' flags that the current decrement brings the count to zero.
module pe_cu_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt;

  // Load has priority over decrement; the count never goes below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == W'(1));

endmodule

// File: rtl/pe_cu_seq_ctrl.sv
// Sequencer for the 8-bank BRAM -> CU -> pe_256 datapath: loads the banks,
// launches a pass from a base address, waits out the pipeline, captures the
// PE result with a timeout guard. Optional build macro PE_CU_SEQ_PERF_EN adds
// the perf_cycles output (ISSUE-entry to DONE-entry cycle count, saturating).
module pe_cu_seq_ctrl
  import pe_cu_pkg::*;
#(
  parameter int AW      = PKG_AW,
  parameter int DW      = PKG_DW,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int CU_LAT  = CU_LAT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_din,
  input  logic          pe_v,
  input  logic [7:0]    pe_d,
  output logic          busy,
  output logic          done,
  output logic [7:0]    result,
  output logic          err_timeout
`ifdef PE_CU_SEQ_PERF_EN
  ,
  output logic [15:0]   perf_cycles
`endif
);

  state_t           state_q, state_n;
  logic [AW-1:0]    wr_cnt, wr_cnt_n;
  logic             ld_last_q, ld_last_n;
  logic             en_n, we_n, busy_n, done_n, err_n;
  logic [AW-1:0]    addr_n;
  logic [DW-1:0]    din_n;
  logic [7:0]       res_n;
  logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
  logic [CNT_W-1:0] cnt_val;
  logic             accept;

  // Ready is combinational so a word can be taken in the same cycle; start wins in IDLE.
  assign load_ready = rst_n & (((state_q == IDLE) & ~start) | (state_q == LOAD));
  assign accept     = load_valid & load_ready;

  pe_cu_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // Next-state and next-value of every registered output.
  always_comb begin
    state_n   = state_q;
    wr_cnt_n  = wr_cnt;
    ld_last_n = 1'b0;
    en_n      = 1'b0;
    we_n      = 1'b0;
    addr_n    = bram_addr;
    din_n     = bram_din;
    done_n    = 1'b0;
    res_n     = result;
    err_n     = err_timeout;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          en_n    = 1'b1;
          addr_n  = base_addr;
          err_n   = 1'b0;
        end else if (accept) begin
          state_n  = LOAD;
          en_n     = 1'b1;
          we_n     = 1'b1;
          addr_n   = wr_cnt;
          din_n    = load_data;
          wr_cnt_n = wr_cnt + AW'(1);
        end
      end
      LOAD: begin
        if (accept) begin
          en_n     = 1'b1;
          we_n     = 1'b1;
          addr_n   = wr_cnt;
          din_n    = load_data;
          wr_cnt_n = wr_cnt + AW'(1);
          if (wr_cnt == AW'(NBANK - 1)) begin
            state_n   = IDLE;
            ld_last_n = 1'b1;
          end
        end
      end
      ISSUE: begin
        en_n     = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(RD_LAT + CU_LAT);
        state_n  = WAIT_PIPE;
      end
      WAIT_PIPE: begin
        en_n    = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_last || cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(TIMEOUT);
          state_n  = WAIT_PE;
        end
      end
      WAIT_PE: begin
        en_n    = 1'b1;
        cnt_dec = 1'b1;
        if (pe_v) begin
          res_n   = pe_d;
          done_n  = 1'b1;
          en_n    = 1'b0;
          state_n = DONE;
        end else if (cnt_last || cnt_zero) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          en_n    = 1'b0;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // busy covers the active run; it drops as done rises.
    busy_n = (state_n == ISSUE) || (state_n == WAIT_PIPE) || (state_n == WAIT_PE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_cnt      <= '0;
      ld_last_q   <= 1'b0;
      load_done   <= 1'b0;
      bram_en     <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_n;
      wr_cnt      <= wr_cnt_n;
      ld_last_q   <= ld_last_n;
      load_done   <= ld_last_q;
      bram_en     <= en_n;
      bram_we     <= we_n;
      bram_addr   <= addr_n;
      bram_din    <= din_n;
      busy        <= busy_n;
      done        <= done_n;
      result      <= res_n;
      err_timeout <= err_n;
    end
  end

`ifdef PE_CU_SEQ_PERF_EN
  logic [15:0] perf_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count from ISSUE entry; publish the count on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (state_q == IDLE && state_n == ISSUE) begin
        perf_cnt <= '0;
      end else if (state_q == ISSUE || state_q == WAIT_PIPE || state_q == WAIT_PE) begin
        perf_cnt <= sat_inc16(perf_cnt);
      end
      if (state_q == WAIT_PE && state_n == DONE) begin
        perf_cycles <= perf_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pe_cu_seq_ctrl.sv
// Bench for pe_cu_seq_ctrl: table of per-cycle vectors plus hand sequences
// for reset mid-load, full reload, timeout and err clearing.
module tb_pe_cu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  base_addr;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready, load_done, bram_en, bram_we;
  logic [2:0]  bram_addr;
  logic [31:0] bram_din;
  logic        pe_v;
  logic [7:0]  pe_d;
  logic        busy, done, err_timeout;
  logic [7:0]  result;
`ifdef PE_CU_SEQ_PERF_EN
  logic [15:0] perf_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pe_cu_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .bram_en     (bram_en),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_din    (bram_din),
    .pe_v        (pe_v),
    .pe_d        (pe_d),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .err_timeout (err_timeout)
`ifdef PE_CU_SEQ_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  ba;
    logic        lv;
    logic [31:0] ld;
    logic        pv;
    logic [7:0]  pd;
    logic        rdy;
    logic        en;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic        ldone;
    logic [7:0]  res;
    logic        err;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic st, input logic [2:0] ba, input logic lv, input logic [31:0] ld,
    input logic pv, input logic [7:0] pd,
    input logic rdy, input logic en, input logic we, input logic [2:0] addr,
    input logic [31:0] din, input logic bs, input logic dn, input logic ldn,
    input logic [7:0] res, input logic err);
    vec_t v;
    v.st = st; v.ba = ba; v.lv = lv; v.ld = ld; v.pv = pv; v.pd = pd;
    v.rdy = rdy; v.en = en; v.we = we; v.addr = addr; v.din = din;
    v.busy = bs; v.done = dn; v.ldone = ldn; v.res = res; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [48:0] pack_out();
    return {bram_en, bram_we, bram_addr, bram_din, busy, done, load_done, result, err_timeout};
  endfunction

  // One run: start at cycle 0, pe_v held from cycle pv_at (negative: never).
  task automatic do_run(input logic [2:0] b, input int pv_at, input logic [7:0] pd,
                        input int exp_cyc, input logic [7:0] exp_res, input logic exp_err);
    int cyc;
    int done_cyc;
    start = 1'b1; base_addr = b; pe_v = 1'b0; pe_d = pd;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    done_cyc = -1;
    chk($sformatf("run_b%0d_issue_addr", b), 64'(bram_addr), 64'(b));
    chk($sformatf("run_b%0d_busy_c1", b), 64'(busy), 64'd1);
    chk($sformatf("run_b%0d_err_clear", b), 64'(err_timeout), 64'd0);
    while (done_cyc < 0 && cyc < 40) begin
      pe_v = (pv_at >= 0) && (cyc >= pv_at);
      @(posedge clk); #1;
      cyc++;
      if (done) done_cyc = cyc;
    end
    pe_v = 1'b0;
    chk($sformatf("run_b%0d_done_cycle", b), 64'(done_cyc), 64'(exp_cyc));
    chk($sformatf("run_b%0d_result", b), 64'(result), 64'(exp_res));
    chk($sformatf("run_b%0d_err", b), 64'(err_timeout), 64'(exp_err));
    @(posedge clk); #1;
    chk($sformatf("run_b%0d_done_pulse", b), 64'({done, busy}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w7, db;
    int ldone_cnt;
    w7 = 32'h88888888;
    db = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(0, 0, 1, 32'h11111111 * 32'(i + 1), 0, 0,
                  1, 1, 1, 3'(i), 32'h11111111 * 32'(i + 1), 0, 0, 0, 8'h00, 0);
    tbl[8]  = mk(0, 0, 0, 0,  0, 0,     1, 0, 0, 7, w7, 0, 0, 1, 8'h00, 0);
    tbl[9]  = mk(0, 0, 0, 0,  0, 0,     1, 0, 0, 7, w7, 0, 0, 0, 8'h00, 0);
    tbl[10] = mk(1, 5, 0, 0,  0, 0,     0, 1, 0, 5, w7, 1, 0, 0, 8'h00, 0);
    tbl[11] = mk(0, 0, 0, 0,  0, 0,     0, 1, 0, 5, w7, 1, 0, 0, 8'h00, 0);
    tbl[12] = mk(0, 0, 0, 0,  1, 8'h3C, 0, 1, 0, 5, w7, 1, 0, 0, 8'h00, 0);
    tbl[13] = mk(0, 0, 0, 0,  1, 8'h3C, 0, 1, 0, 5, w7, 1, 0, 0, 8'h00, 0);
    tbl[14] = mk(0, 0, 0, 0,  1, 8'h7E, 0, 0, 0, 5, w7, 0, 1, 0, 8'h7E, 0);
    tbl[15] = mk(0, 0, 0, 0,  0, 0,     0, 0, 0, 5, w7, 0, 0, 0, 8'h7E, 0);
    tbl[16] = mk(1, 7, 1, db, 0, 0,     0, 1, 0, 7, w7, 1, 0, 0, 8'h7E, 0);
    tbl[17] = mk(0, 0, 1, db, 0, 0,     0, 1, 0, 7, w7, 1, 0, 0, 8'h7E, 0);
    tbl[18] = mk(0, 0, 1, db, 0, 0,     0, 1, 0, 7, w7, 1, 0, 0, 8'h7E, 0);
    tbl[19] = mk(0, 0, 1, db, 0, 0,     0, 1, 0, 7, w7, 1, 0, 0, 8'h7E, 0);
    tbl[20] = mk(0, 0, 1, db, 1, 8'hA5, 0, 0, 0, 7, w7, 0, 1, 0, 8'hA5, 0);
    tbl[21] = mk(0, 0, 1, db, 0, 0,     0, 0, 0, 7, w7, 0, 0, 0, 8'hA5, 0);
    tbl[22] = mk(0, 0, 1, db, 0, 0,     1, 1, 1, 0, db, 0, 0, 0, 8'hA5, 0);
    tbl[23] = mk(0, 0, 1, 32'h0BADF00D, 0, 0, 1, 1, 1, 1, 32'h0BADF00D, 0, 0, 0, 8'hA5, 0);
    tbl[24] = mk(0, 0, 1, 32'hCAFEF00D, 0, 0, 1, 1, 1, 2, 32'hCAFEF00D, 0, 0, 0, 8'hA5, 0);

    rst_n = 1'b0; start = 1'b0; base_addr = '0; load_valid = 1'b0;
    load_data = '0; pe_v = 1'b0; pe_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(pack_out()), 64'd0);
    chk("reset_load_ready", 64'(load_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      start = tbl[i].st; base_addr = tbl[i].ba; load_valid = tbl[i].lv;
      load_data = tbl[i].ld; pe_v = tbl[i].pv; pe_d = tbl[i].pd;
      #1;
      chk($sformatf("row%0d_load_ready", i), 64'(load_ready), 64'(tbl[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("row%0d_outputs", i), 64'(pack_out()),
          64'({tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].busy,
               tbl[i].done, tbl[i].ldone, tbl[i].res, tbl[i].err}));
`ifdef PE_CU_SEQ_PERF_EN
      if (i == 14) chk("perf_cycles", 64'(perf_cycles), 64'd3);
`endif
    end

    // Asynchronous reset in the middle of a load (3 words in).
    #2;
    rst_n = 1'b0;
    #1;
    chk("midload_reset_outputs", 64'(pack_out()), 64'd0);
    chk("midload_reset_ready", 64'(load_ready), 64'd0);
    start = 1'b0; pe_v = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Full reload from address 0; load_done must fire exactly once.
    ldone_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hA0000000 + 32'(i);
      @(posedge clk); #1;
      if (load_done) ldone_cnt++;
      chk($sformatf("reload_w%0d", i), 64'({bram_en, bram_we, bram_addr, bram_din}),
          64'({1'b1, 1'b1, 3'(i), 32'hA0000000 + 32'(i)}));
    end
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (load_done) ldone_cnt++;
    end
    chk("reload_load_done_count", 64'(ldone_cnt), 64'd1);

    do_run(3'd3, 4, 8'h99, 5, 8'h99, 1'b0);
    do_run(3'd2, -1, 8'h44, 20, 8'h99, 1'b1);
    do_run(3'd6, 2, 8'h5A, 5, 8'h5A, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
